// File: rtl/ped_crossing_controller_pkg.sv
// ped_pkg: shared types and defaults for the pedestrian crossing controller.
//   ped_state_t    : FSM state encoding (2 bits)
//   CNT_W          : width of the phase counter and the countdown output
//   *_DEF          : default phase lengths in clk cycles
//   lamps_illegal(): true unless exactly one vehicle lamp is lit
package ped_pkg;

  localparam int CNT_W         = 4;
  localparam int WALK_CYC_DEF  = 5;
  localparam int FLASH_CYC_DEF = 4;
  localparam int RED_CYC_DEF   = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RED = 2'd1,
    WALK     = 2'd2,
    FLASH    = 2'd3
  } ped_state_t;

  function automatic logic lamps_illegal(input logic red, input logic yellow, input logic green);
    logic [1:0] lit;
    lit = {1'b0, red} + {1'b0, yellow} + {1'b0, green};
    return lit != 2'd1;
  endfunction

endpackage

// File: rtl/ped_crossing_controller_btn_sync_edge.sv
// btn_sync_edge: brings an asynchronous button into the clk domain and
// produces a registered one-cycle pulse on each rising edge.
//   clk  : clock
//   rst  : asynchronous active-high reset (all flops clear to 0)
//   din  : asynchronous level input
//   rise : one-cycle pulse, asserted two edges after din is first captured
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      sync2_q <= sync2;
      rise    <= sync2 & ~sync2_q;
    end
  end

endmodule

// File: rtl/ped_crossing_controller.sv
// ped_crossing_controller: pedestrian WALK / DON'T WALK head slaved to the
// one-hot lamps of the upstream vehicle controller. A walk is granted only at
// the start of a vehicle red phase; illegal lamp combinations latch a fault.
//   clk, rst                        : clock, asynchronous active-high reset
//   ped_btn                         : pedestrian button (asynchronous)
//   veh_red, veh_yellow, veh_green  : upstream vehicle lamps
//   walk, dont_walk                 : pedestrian lamps (dont_walk flashes in clearance)
//   countdown                       : remaining clearance cycles in FLASH, else 0
//   req_pending                     : request latched, waiting for next red
//   req_ack                         : pulse on first WALK cycle
//   abort                           : pulse when red drops during WALK/FLASH
//   fault                           : sticky illegal-lamp flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request, DON'T WALK solid (also the only state in fault)
// WAIT_RED | request latched, waiting for the next vehicle red edge
// WALK     | WALK lit for WALK_CYC cycles
// FLASH    | DON'T WALK flashing with countdown for FLASH_CYC cycles
module ped_crossing_controller
  import ped_pkg::*;
#(
  parameter int WALK_CYC  = WALK_CYC_DEF,
  parameter int FLASH_CYC = FLASH_CYC_DEF,
  parameter int RED_CYC   = RED_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ped_btn,
  input  logic             veh_red,
  input  logic             veh_yellow,
  input  logic             veh_green,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             req_pending,
  output logic             req_ack,
  output logic             abort,
  output logic             fault
);

  // The whole walk + clearance must end inside one red phase, with one
  // spare cycle for the red-edge detection latency.
  if (WALK_CYC < 1 || WALK_CYC > 15 || FLASH_CYC < 1 || FLASH_CYC > 15 ||
      WALK_CYC + FLASH_CYC > RED_CYC - 1) begin : g_param_err
    $error("ped_crossing_controller: illegal WALK_CYC/FLASH_CYC/RED_CYC combination");
  end

  localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_CYC);
  localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_CYC);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(1);

  ped_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             veh_red_q;
  logic             btn_rise;
  logic             red_rise;
  logic             illegal;

  logic             pend_d;
  logic             ack_d;
  logic             abort_d;
  logic             fault_d;
  logic             walk_d;
  logic             dont_walk_d;
  logic [CNT_W-1:0] countdown_d;

  btn_sync_edge u_btn (
    .clk  (clk),
    .rst  (rst),
    .din  (ped_btn),
    .rise (btn_rise)
  );

  // veh_red_q resets high so a red already lit at reset is not a fresh edge.
  assign red_rise = veh_red & ~veh_red_q;
  assign illegal  = lamps_illegal(veh_red, veh_yellow, veh_green);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      veh_red_q   <= 1'b1;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      countdown   <= '0;
      req_pending <= 1'b0;
      req_ack     <= 1'b0;
      abort       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      veh_red_q   <= veh_red;
      walk        <= walk_d;
      dont_walk   <= dont_walk_d;
      countdown   <= countdown_d;
      req_pending <= pend_d;
      req_ack     <= ack_d;
      abort       <= abort_d;
      fault       <= fault_d;
    end
  end

  // Phase counter is a down-counter loaded on state entry; the phase ends on
  // the cycle it reads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = req_pending;
    ack_d   = 1'b0;
    abort_d = 1'b0;
    fault_d = fault | illegal;

    if (fault || illegal) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (btn_rise) begin
            state_d = WAIT_RED;
            pend_d  = 1'b1;
          end
        end
        WAIT_RED: begin
          // A press on this same edge is absorbed into the walk being granted.
          if (red_rise) begin
            state_d = WALK;
            cnt_d   = WALK_LD;
            pend_d  = 1'b0;
            ack_d   = 1'b1;
          end
        end
        WALK: begin
          if (!veh_red) begin
            state_d = req_pending ? WAIT_RED : IDLE;
            cnt_d   = '0;
            abort_d = 1'b1;
          end else if (cnt_q == CNT_TC) begin
            state_d = FLASH;
            cnt_d   = FLASH_LD;
          end else begin
            cnt_d = cnt_q - CNT_TC;
          end
        end
        FLASH: begin
          pend_d = req_pending | btn_rise;
          if (!veh_red) begin
            state_d = pend_d ? WAIT_RED : IDLE;
            cnt_d   = '0;
            abort_d = 1'b1;
          end else if (cnt_q == CNT_TC) begin
            state_d = pend_d ? WAIT_RED : IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_TC;
          end
        end
      endcase
    end
  end

  // Outputs are computed from the next state so the lamps are flop outputs.
  always_comb begin
    walk_d      = (state_d == WALK);
    countdown_d = '0;
    dont_walk_d = ~walk_d;
    if (state_d == FLASH) begin
      countdown_d = cnt_d;
      dont_walk_d = (state_q == FLASH) ? ~dont_walk : 1'b1;
    end
  end

endmodule

// File: tb/tb_ped_crossing_controller.sv
module tb_ped_crossing_controller;

  localparam int W = 5;
  localparam int F = 4;
  localparam int R = 10;
  localparam logic [9:0] RST_V = {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_btn = 1'b0;
  logic       veh_red, veh_yellow, veh_green;
  logic       walk, dont_walk, req_pending, req_ack, abort, fault;
  logic [3:0] countdown;
  logic [9:0] dut_v;

  ped_crossing_controller #(.WALK_CYC(W), .FLASH_CYC(F), .RED_CYC(R)) dut (
    .clk         (clk),
    .rst         (rst),
    .ped_btn     (ped_btn),
    .veh_red     (veh_red),
    .veh_yellow  (veh_yellow),
    .veh_green   (veh_green),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .countdown   (countdown),
    .req_pending (req_pending),
    .req_ack     (req_ack),
    .abort       (abort),
    .fault       (fault)
  );

  assign dut_v = {walk, dont_walk, countdown, req_pending, req_ack, abort, fault};

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt;
  int   obs_ack = 0;
  int   obs_abort = 0;

  // reference model: walk described as a position within the crossing sequence
  int         m_p = -1;      // -1: no walk; 0..W-1 walk; W..W+F-1 clearance
  logic       m_pend = 1'b0;
  logic       m_fault = 1'b0;
  logic [4:0] bh = '0;       // bh[k]: button level seen k edges before the upcoming one
  logic       red_prev = 1'b1;
  int         m_ack_cnt = 0;
  int         m_abort_cnt = 0;

  int light_pos = R;         // upstream position 0..3R-1: red, green, yellow
  int press_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got {walk,dw,cd,pend,ack,abort,fault}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_p = -1; m_pend = 1'b0; m_fault = 1'b0; bh = '0; red_prev = 1'b1;
  endtask

  // Predict the outputs after the upcoming edge from the inputs now driven.
  task automatic model_and_push();
    logic       rise, rrise, ill, ack, ab, w, dw;
    logic [3:0] cd;
    exp_t       e;
    bh    = {bh[3:0], ped_btn};
    rise  = bh[3] & ~bh[4];
    rrise = veh_red & ~red_prev;
    red_prev = veh_red;
    ill   = $countones({veh_red, veh_yellow, veh_green}) != 1;
    ack = 1'b0; ab = 1'b0;
    if (m_fault || ill) begin
      m_fault = 1'b1; m_pend = 1'b0; m_p = -1;
    end else if (m_p >= 0) begin
      if (m_p >= W && rise) m_pend = 1'b1;
      if (!veh_red) begin
        ab = 1'b1; m_p = -1;
      end else begin
        m_p++;
        if (m_p == W + F) m_p = -1;
      end
    end else if (m_pend) begin
      if (rrise) begin m_p = 0; m_pend = 1'b0; ack = 1'b1; end
    end else if (rise) begin
      m_pend = 1'b1;
    end
    w  = (m_p >= 0) && (m_p < W);
    cd = '0;
    dw = ~w;
    if (m_p >= W) begin
      cd = 4'(W + F - m_p);
      dw = ((m_p - W) % 2) == 0;
    end
    m_ack_cnt   += int'(ack);
    m_abort_cnt += int'(ab);
    e.tag = edge_cnt + 1;
    e.v   = {w, dw, cd, m_pend, ack, ab, m_fault};
    sb.push_back(e);
  endtask

  task automatic drive_lamps();
    veh_red    = (light_pos < R);
    veh_green  = (light_pos >= R) && (light_pos < 2 * R);
    veh_yellow = (light_pos >= 2 * R);
  endtask

  task automatic step(input logic ill);
    @(posedge clk); #1;
    if (press_left > 0) begin ped_btn = 1'b1; press_left--; end
    else ped_btn = 1'b0;
    drive_lamps();
    if (ill) begin veh_red = 1'b1; veh_green = 1'b1; veh_yellow = 1'b0; end
    light_pos = (light_pos + 1) % (3 * R);
    model_and_push();
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    model_and_push();
  endtask

  task automatic wait_pos(input int target, input int budget, input string name);
    int n = 0;
    while (m_p != target && n < budget) begin step(1'b0); n++; end
    checks++;
    if (m_p != target) begin
      failures++;
      $display("FAIL %s walk position %0d not reached within %0d cycles", name, target, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!(m_p < 0 && !m_pend && bh == '0 && press_left == 0) && n < budget) begin
      step(1'b0); n++;
    end
    checks++;
    if (!(m_p < 0 && !m_pend)) begin
      failures++;
      $display("FAIL %s not idle within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_light(input int target);
    int n = 0;
    while (light_pos != target && n < 3 * R) begin step(1'b0); n++; end
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (sb.size() > 0 && sb[0].tag < edge_cnt) begin
          checks++; failures++;
          $display("FAIL sb_stale expectation for edge %0d unchecked at edge %0d", sb[0].tag, edge_cnt);
          sb.delete(0);
        end
        if (sb.size() > 0 && sb[0].tag == edge_cnt) begin
          e = sb.pop_front();
          obs_ack   += int'(req_ack);
          obs_abort += int'(abort);
          chk($sformatf("edge%0d", edge_cnt), dut_v, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_lamps();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", dut_v, RST_V);
    release_rst();

    // press during green, served at next red
    repeat (2) step(1'b0);
    press_left = 3;
    wait_pos(0, 40, "green_press_walk");
    wait_idle(60, "green_press_done");

    // press in the middle of red: must wait for the following red
    wait_light($urandom_range(3, 6));
    press_left = 3;
    wait_pos(0, 60, "mid_red_walk");
    wait_idle(60, "mid_red_done");

    // second press lands in clearance: re-served next red
    wait_light(12);
    press_left = 3;
    wait_pos($urandom_range(W - 3, W + F - 4), 40, "flash_press_pos");
    press_left = 2;
    wait_idle(80, "flash_press_done");

    // red drops on the 3rd WALK cycle
    wait_light(12);
    press_left = 3;
    wait_pos(2, 40, "abort_pos");
    light_pos = R;
    step(1'b0);
    wait_idle(60, "abort_done");

    // random soak
    for (int i = 0; i < 300; i++) begin
      if (press_left == 0 && ped_btn == 1'b0 && $urandom_range(0, 5) == 0)
        press_left = $urandom_range(1, 4);
      step(1'b0);
    end
    wait_idle(80, "soak_done");

    // asynchronous reset in WALK, then no press through the next red
    wait_light(12);
    press_left = 3;
    wait_pos(1, 40, "rst_walk_pos");
    @(posedge clk); #3;
    rst = 1'b1; ped_btn = 1'b0; press_left = 0;
    #1;
    chk("reset_mid_walk", dut_v, RST_V);
    sb.delete();
    repeat (2) @(posedge clk);
    release_rst();
    repeat (40) step(1'b0);

    // illegal lamps: sticky fault, presses ignored
    step(1'b1);
    for (int k = 0; k < 3; k++) begin
      press_left = 3;
      repeat (15) step(1'b0);
    end
    wait_idle(20, "fault_idle");

    repeat (2) @(negedge clk);
    #1;
    chk_int("sb_drained", sb.size(), 0);
    chk_int("ack_total", obs_ack, m_ack_cnt);
    chk_int("abort_total", obs_abort, m_abort_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
